// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU unit: radix-2 restoring divider, one quotient bit per cycle.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iteration and finishes in one cycle.
module div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_start_E,
    input  logic        div_signed_E,
    input  logic [31:0] a_E,
    input  logic [31:0] b_E,
    input  logic        flush_exception_M,
    output logic        div_stall_E,
    output logic        div_ready_E,
    output logic [31:0] lo_E,
    output logic [31:0] hi_E
);

`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST_ZERO = 1'b1;
`else
    localparam bit FAST_ZERO = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic        signed_q;
    logic        a_neg_q;
    logic        b_neg_q;
    logic        zero_q;
    logic        ready_q;
    logic [31:0] lo_q;
    logic [31:0] hi_q;

    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] rem_shift;
    logic        ge;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;
    logic        neg_quo;
    logic        neg_rem;
    logic [31:0] lo_nx;
    logic [31:0] hi_nx;

    always_comb begin
        a_abs     = (div_signed_E && a_E[31]) ? (~a_E + 32'd1) : a_E;
        b_abs     = (div_signed_E && b_E[31]) ? (~b_E + 32'd1) : b_E;
        // The partial remainder stays below the divisor, so a 32-bit wrapping
        // subtract is exact whenever the 33-bit compare says it fits.
        rem_shift = {rem_q, quo_q[31]};
        ge        = (rem_shift >= {1'b0, dvs_q});
        rem_nx    = ge ? (rem_shift[31:0] - dvs_q) : rem_shift[31:0];
        quo_nx    = {quo_q[30:0], ge};
        neg_quo   = signed_q & (a_neg_q ^ b_neg_q);
        neg_rem   = signed_q & a_neg_q;
        lo_nx     = zero_q ? 32'hFFFF_FFFF : (neg_quo ? (~quo_nx + 32'd1) : quo_nx);
        hi_nx     = neg_rem ? (~rem_nx + 32'd1) : rem_nx;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            dvs_q    <= 32'd0;
            signed_q <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            zero_q   <= 1'b0;
            ready_q  <= 1'b0;
            lo_q     <= 32'd0;
            hi_q     <= 32'd0;
        end else if (flush_exception_M) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (div_start_E) begin
                        signed_q <= div_signed_E;
                        a_neg_q  <= div_signed_E & a_E[31];
                        b_neg_q  <= div_signed_E & b_E[31];
                        zero_q   <= (b_E == 32'd0);
                        rem_q    <= 32'd0;
                        quo_q    <= a_abs;
                        dvs_q    <= b_abs;
                        cnt_q    <= 5'd0;
                        if (FAST_ZERO && (b_E == 32'd0)) begin
                            state_q <= DONE;
                            ready_q <= 1'b1;
                            lo_q    <= 32'hFFFF_FFFF;
                            hi_q    <= a_E;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= DONE;
                        ready_q <= 1'b1;
                        lo_q    <= lo_nx;
                        hi_q    <= hi_nx;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign div_stall_E = resetn & ~flush_exception_M &
                         (((state_q == IDLE) & div_start_E) | (state_q == BUSY));
    assign div_ready_E = ready_q;
    assign lo_E        = lo_q;
    assign hi_E        = hi_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic/latency model checked every cycle plus literal vectors.
module tb_div_unit;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZSTALL = 1;
    localparam int ZLAT   = 0;
`else
    localparam int ZSTALL = 33;
    localparam int ZLAT   = 32;
`endif

    logic        clk;
    logic        resetn;
    logic        div_start_E;
    logic        div_signed_E;
    logic [31:0] a_E;
    logic [31:0] b_E;
    logic        flush_exception_M;
    logic        div_stall_E;
    logic        div_ready_E;
    logic [31:0] lo_E;
    logic [31:0] hi_E;

    int n_cmp = 0;
    int n_err = 0;

    div_unit dut (
        .clk               (clk),
        .resetn            (resetn),
        .div_start_E       (div_start_E),
        .div_signed_E      (div_signed_E),
        .a_E               (a_E),
        .b_E               (b_E),
        .flush_exception_M (flush_exception_M),
        .div_stall_E       (div_stall_E),
        .div_ready_E       (div_ready_E),
        .lo_E              (lo_E),
        .hi_E              (hi_E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result {hi, lo}: truncating division, remainder follows dividend.
    function automatic logic [63:0] exp_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Latency model: an accepted start finishes after a fixed count of busy cycles.
    bit          m_active = 0;
    int          m_cnt    = 0;
    logic [63:0] m_pend   = '0;
    logic [31:0] m_lo     = '0;
    logic [31:0] m_hi     = '0;

    initial begin
        bit e_ready, e_stall, busy;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                m_active = 0;
                m_cnt    = 0;
                m_lo     = '0;
                m_hi     = '0;
                e_ready  = 0;
                e_stall  = 0;
                busy     = 0;
            end else begin
                e_ready = m_active && (m_cnt == 0);
                busy    = m_active && (m_cnt > 0);
                e_stall = !flush_exception_M && ((!m_active && div_start_E) || busy);
                if (e_ready) {m_hi, m_lo} = m_pend;
            end
            chk("cyc_stall", {63'd0, div_stall_E}, {63'd0, e_stall});
            chk("cyc_ready", {63'd0, div_ready_E}, {63'd0, e_ready});
            chk("cyc_lo", {32'd0, lo_E}, {32'd0, m_lo});
            chk("cyc_hi", {32'd0, hi_E}, {32'd0, m_hi});
            if (resetn) begin
                if (flush_exception_M)       m_active = 0;
                else if (e_ready)            m_active = 0;
                else if (busy)               m_cnt--;
                else if (div_start_E) begin
                    m_active = 1;
                    m_cnt    = (b_E == 32'd0) ? ZLAT : 32;
                    m_pend   = exp_div(a_E, b_E, div_signed_E);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b, input bit sgn,
                          input logic [31:0] elo, input logic [31:0] ehi, input int estall, input bit keep);
        int stalls = 0;
        bit seen = 0;
        div_start_E  = 1'b1;
        div_signed_E = sgn;
        a_E          = a;
        b_E          = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (div_ready_E) begin
                seen = 1;
                chk({nm, "_lo"}, {32'd0, lo_E}, {32'd0, elo});
                chk({nm, "_hi"}, {32'd0, hi_E}, {32'd0, ehi});
                break;
            end
            if (div_stall_E) stalls++;
            tick();
            a_E = $urandom;
            b_E = $urandom;
        end
        chk({nm, "_done"}, {63'd0, seen}, 64'd1);
        chk({nm, "_stalls"}, 64'(stalls), 64'(estall));
        tick();
        if (!keep) div_start_E = 1'b0;
    endtask

    initial begin
        int nrdy;
        resetn            = 1'b0;
        div_start_E       = 1'b1;
        div_signed_E      = 1'b0;
        a_E               = 32'd100;
        b_E               = 32'd7;
        flush_exception_M = 1'b0;
        repeat (3) tick();
        chk("rst_stall", {63'd0, div_stall_E}, 64'd0);
        chk("rst_lo", {32'd0, lo_E}, 64'd0);
        resetn      = 1'b1;
        div_start_E = 1'b0;
        tick();

        chk("model_u100_7", exp_div(32'd100, 32'd7, 0), {32'd2, 32'd14});
        chk("model_s-100_7", exp_div(32'hFFFF_FF9C, 32'd7, 1), {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        chk("model_min_m1", exp_div(32'h8000_0000, 32'hFFFF_FFFF, 1), {32'd0, 32'h8000_0000});
        chk("model_5_0", exp_div(32'd5, 32'd0, 0), {32'd5, 32'hFFFF_FFFF});

        run_op("divu_100_7", 32'd100, 32'd7, 0, 32'd14, 32'd2, 33, 0);
        run_op("div_m100_7", 32'hFFFF_FF9C, 32'd7, 1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33, 0);
        run_op("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 32'd0, 33, 0);
        run_op("div_100_m7", 32'd100, 32'hFFFF_FFF9, 1, 32'hFFFF_FFF2, 32'd2, 33, 0);
        run_op("divu_5_0", 32'd5, 32'd0, 0, 32'hFFFF_FFFF, 32'd5, ZSTALL, 0);
        run_op("div_m5_0", 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, ZSTALL, 0);
        run_op("divu_7_100", 32'd7, 32'd100, 0, 32'd0, 32'd7, 33, 0);
        run_op("divu_max_1", 32'hFFFF_FFFF, 32'd1, 0, 32'hFFFF_FFFF, 32'd0, 33, 0);

        // Flush in the tenth busy cycle must discard the division.
        div_start_E  = 1'b1;
        div_signed_E = 1'b0;
        a_E          = 32'd100;
        b_E          = 32'd7;
        tick();
        div_start_E = 1'b0;
        repeat (9) tick();
        flush_exception_M = 1'b1;
        @(negedge clk);
        chk("flush_stall", {63'd0, div_stall_E}, 64'd0);
        tick();
        flush_exception_M = 1'b0;
        nrdy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_ready_E) nrdy++;
        end
        chk("flush_no_ready", 64'(nrdy), 64'd0);
        chk("flush_lo_kept", {32'd0, lo_E}, {32'd0, 32'hFFFF_FFFF});
        chk("flush_hi_kept", {32'd0, hi_E}, 64'd0);
        tick();

        // Flush together with a start in IDLE: nothing starts.
        div_start_E       = 1'b1;
        flush_exception_M = 1'b1;
        a_E               = 32'd9;
        b_E               = 32'd3;
        tick();
        div_start_E       = 1'b0;
        flush_exception_M = 1'b0;
        nrdy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_ready_E || div_stall_E) nrdy++;
        end
        chk("flush_start_idle", 64'(nrdy), 64'd0);
        tick();

        run_op("b2b_first", 32'd50, 32'd5, 0, 32'd10, 32'd0, 33, 1);
        run_op("b2b_second", 32'd81, 32'd9, 0, 32'd9, 32'd0, 33, 0);

        // Reset in the twentieth busy cycle aborts; start held high during reset.
        div_start_E  = 1'b1;
        div_signed_E = 1'b0;
        a_E          = 32'd100;
        b_E          = 32'd7;
        tick();
        repeat (19) tick();
        resetn = 1'b0;
        #1;
        chk("midrst_lo", {32'd0, lo_E}, 64'd0);
        chk("midrst_hi", {32'd0, hi_E}, 64'd0);
        chk("midrst_ready", {63'd0, div_ready_E}, 64'd0);
        chk("midrst_stall", {63'd0, div_stall_E}, 64'd0);
        repeat (2) tick();
        resetn = 1'b1;
        run_op("divu_9_3", 32'd9, 32'd3, 0, 32'd3, 32'd0, 33, 0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL expose: clk  input  1  pipeline clock, rising edge.
REQ-002 The block SHALL expose: resetn  input  1  reset, asynchronous, active-low.
REQ-003 The block SHALL expose: div_start_E  input  1  DIV/DIVU instruction valid in Execute.
REQ-004 The block SHALL expose: div_signed_E  input  1  1 = DIV, 0 = DIVU; sampled with div_start_E.
REQ-005 The block SHALL expose: a_E  input  32  dividend (rs value after forwarding).
REQ-006 The block SHALL expose: b_E  input  32  divisor (rt value after forwarding).
REQ-007 The block SHALL expose: flush_exception_M  input  1  cancels any division in progress.
REQ-008 The block SHALL expose: div_stall_E  output  1  stall request; ORed into alu_stall_E for the hazard unit.
REQ-009 The block SHALL expose: div_ready_E  output  1  quotient and remainder are valid this cycle.
REQ-010 The block SHALL expose: lo_E  output  32  quotient, destined for LO.
REQ-011 The block SHALL expose: hi_E  output  32  remainder, destined for HI.

Function
REQ-012 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-013 In IDLE with div_start_E=1, the block SHALL latch |a|, |b|, the sign flags and div_signed_E, clear the 5-bit iteration counter, and enter BUSY.
REQ-014 BUSY SHALL perform one radix-2 restoring step per cycle for exactly 32 cycles (counter 0..31), then enter DONE.
REQ-015 DONE SHALL last exactly one cycle, assert div_ready_E, and return to IDLE unconditionally; div_start_E is ignored in DONE.
REQ-016 div_stall_E SHALL be combinational: ~flush_exception_M & ((IDLE & div_start_E) | BUSY); it is 0 in DONE, so the stage advances at the end of the DONE cycle.
REQ-017 Latency from the div_start_E cycle to div_ready_E SHALL be 34 cycles, with 33 stalled cycles.
REQ-018 In signed mode the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-019 0x80000000 / 0xFFFFFFFF signed SHALL give lo=0x80000000 and hi=0.
REQ-020 Divisor zero SHALL give lo=0xFFFFFFFF and hi=a_E, regardless of signedness.
REQ-021 lo_E and hi_E SHALL hold their last result until the next DONE; they do not change in IDLE or BUSY.
REQ-022 flush_exception_M=1 in any state SHALL force IDLE on the next edge, discard the partial result, leave lo_E and hi_E unchanged, and keep div_ready_E at 0.
REQ-023 If flush_exception_M and div_start_E are both 1 in IDLE, no division SHALL start.
REQ-024 Operands SHALL be sampled only at the start; changes to a_E or b_E during BUSY have no effect.

Reset
REQ-025 resetn=0 SHALL asynchronously force IDLE, counter=0, lo_E=0, hi_E=0, div_ready_E=0 and all internal operand registers to 0.
REQ-026 With resetn=0, div_stall_E SHALL be 0 regardless of div_start_E.
REQ-027 Reset asserted mid-division SHALL abort it, with the same result as REQ-025.
REQ-028 The first start after reset release SHALL begin at the next clk edge.

Configuration
REQ-029 With DIV_ZERO_FAST_EN defined, a start with b_E=0 in IDLE SHALL go directly to DONE, giving 1 stalled cycle and div_ready_E on the next cycle, with the REQ-020 values.
REQ-030 Without DIV_ZERO_FAST_EN, a zero divisor SHALL take the full 32-cycle BUSY path with identical result values.

Verification
REQ-031 DIVU 100/7 -> div_stall_E high for 33 cycles; then div_ready_E=1 with lo=14, hi=2.
REQ-032 DIV 0xFFFFFF9C(-100)/7 -> lo=0xFFFFFFF2(-14), hi=0xFFFFFFFE(-2); DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 DIVU 5/0 -> lo=0xFFFFFFFF, hi=5; stall is 33 cycles, or 1 cycle when DIV_ZERO_FAST_EN is defined.
REQ-034 Start DIVU 100/7, then pulse flush_exception_M at BUSY cycle 10 -> div_stall_E=0 in that cycle, IDLE next cycle, div_ready_E never asserted, lo/hi keep their prior values.
REQ-035 Drive resetn=0 at BUSY cycle 20 -> outputs 0 immediately; a new DIVU 9/3 after release -> lo=3, hi=0.
REQ-036 Two back-to-back DIVU instructions (start held through DONE) -> the second starts in the IDLE cycle following DONE, giving two distinct div_ready_E pulses with correct results.
